// File: rtl/avg_pkg.sv
// rtl/avg_pkg.sv - shared types and register map for the moving-average sequencer
package avg_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] SUM_ADDR  = 5'd1;
    localparam logic [ADDR_W-1:0] SLOT_BASE = 5'd16;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_LOAD = 2'b01,
        OP_ADD  = 2'b10,
        OP_SUB  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_SUB,
        ST_LOAD,
        ST_ADD,
        ST_READ
    } state_e;

    function automatic logic [ADDR_W-1:0] slot_addr(input logic [ADDR_W-2:0] idx);
        return SLOT_BASE + {1'b0, idx};
    endfunction

endpackage

// File: rtl/avg_window_ptr.sv
// rtl/avg_window_ptr.sv - circular slot pointer, saturating sample count and window-full flag
module avg_window_ptr #(
    parameter int WINDOW_LOG2 = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_advance,
    output logic [WINDOW_LOG2-1:0] o_ptr,
    output logic [WINDOW_LOG2-1:0] o_ptr_next,
    output logic                   o_window_full
);

    localparam int CNT_W = WINDOW_LOG2 + 1;
    localparam logic [CNT_W-1:0] N_CNT = CNT_W'(1 << WINDOW_LOG2);

    logic [WINDOW_LOG2-1:0] r_ptr;
    logic [CNT_W-1:0]       r_count;
    logic                   r_full;

    // Natural wrap of the WINDOW_LOG2-bit pointer gives N-1 -> 0.
    assign o_ptr_next = r_ptr + WINDOW_LOG2'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr   <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else if (i_advance) begin
            r_ptr <= o_ptr_next;
            if (r_count != N_CNT) begin
                r_count <= r_count + CNT_W'(1);
            end
            if (r_count == N_CNT - CNT_W'(1)) begin
                r_full <= 1'b1;
            end
        end
    end

    assign o_ptr         = r_ptr;
    assign o_window_full = r_full;

endmodule

// File: rtl/avg_sequencer.sv
// rtl/avg_sequencer.sv - drives the register-file datapath to maintain a windowed price average
module avg_sequencer
    import avg_pkg::*;
#(
    parameter int WINDOW_LOG2 = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] stock_price,
    input  logic              data_ready,
    input  logic [DATA_W-1:0] data_out,
    output logic [ADDR_W-1:0] address_one,
    output logic [ADDR_W-1:0] address_two,
    output logic [1:0]        op_code,
    output logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] average,
    output logic              avg_valid,
    output logic              busy,
    output logic              window_full,
    output logic              overrun
);

    localparam logic [4:0] INIT_LAST = 5'(1 << WINDOW_LOG2);

    state_e            r_state;
    state_e            w_state_next;
    logic [4:0]        r_init_cnt;
    logic [4:0]        w_init_cnt_next;

    op_e               r_op;
    op_e               w_op_next;
    logic [ADDR_W-1:0] r_a1;
    logic [ADDR_W-1:0] r_a2;
    logic [ADDR_W-1:0] w_a1_next;
    logic [ADDR_W-1:0] w_a2_next;
    logic [DATA_W-1:0] r_load;
    logic [DATA_W-1:0] w_load_next;

    logic [DATA_W-1:0] r_price;
    logic              r_pend_valid;
    logic [DATA_W-1:0] r_pend_price;
    logic [DATA_W-1:0] r_average;
    logic              r_avg_valid;
    logic              r_overrun;

    logic [WINDOW_LOG2-1:0] w_ptr;
    logic [WINDOW_LOG2-1:0] w_ptr_next;
    logic                   w_window_full;
    logic                   w_advance;
    logic                   w_start;
    logic                   w_pend_load;
    logic                   w_drop;
    logic [ADDR_W-2:0]      w_init_idx;
    logic [ADDR_W-1:0]      w_slot;
    logic [ADDR_W-1:0]      w_start_slot;

    avg_window_ptr #(
        .WINDOW_LOG2 (WINDOW_LOG2)
    ) u_window_ptr (
        .clk           (clk),
        .rst           (rst),
        .i_advance     (w_advance),
        .o_ptr         (w_ptr),
        .o_ptr_next    (w_ptr_next),
        .o_window_full (w_window_full)
    );

    assign w_advance = (r_state == ST_READ);

    // A sequence may start from IDLE or straight out of READ (back-to-back samples).
    assign w_start = ((r_state == ST_IDLE) || (r_state == ST_READ)) && (data_ready || r_pend_valid);

    // When starting with a pending sample, a new strobe refills the buffer; otherwise it is taken directly.
    assign w_pend_load = data_ready && (w_start ? r_pend_valid : !r_pend_valid);
    assign w_drop      = data_ready && !w_start && r_pend_valid;

    assign w_init_idx   = (ADDR_W-1)'(r_init_cnt - 5'd1);
    assign w_slot       = slot_addr((ADDR_W-1)'(w_ptr));
    // Leaving READ, the pointer advances on the same edge, so SUB must address the next slot.
    assign w_start_slot = (r_state == ST_READ) ? slot_addr((ADDR_W-1)'(w_ptr_next)) : w_slot;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
            r_op       <= OP_NOP;
            r_a1       <= '0;
            r_a2       <= '0;
            r_load     <= '0;
        end else begin
            r_state    <= w_state_next;
            r_init_cnt <= w_init_cnt_next;
            r_op       <= w_op_next;
            r_a1       <= w_a1_next;
            r_a2       <= w_a2_next;
            r_load     <= w_load_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_init_cnt_next = r_init_cnt;
        w_op_next       = OP_NOP;
        w_a1_next       = '0;
        w_a2_next       = '0;
        w_load_next     = '0;
        case (r_state)
            ST_INIT: begin
                if (r_init_cnt <= INIT_LAST) begin
                    w_op_next       = OP_LOAD;
                    w_a1_next       = (r_init_cnt == 5'd0) ? SUM_ADDR : slot_addr(w_init_idx);
                    w_init_cnt_next = r_init_cnt + 5'd1;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_IDLE, ST_READ: begin
                if (w_start) begin
                    w_state_next = ST_SUB;
                    w_op_next    = OP_SUB;
                    w_a1_next    = SUM_ADDR;
                    w_a2_next    = w_start_slot;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SUB: begin
                w_state_next = ST_LOAD;
                w_op_next    = OP_LOAD;
                w_a1_next    = w_slot;
                w_load_next  = r_price;
            end
            ST_LOAD: begin
                w_state_next = ST_ADD;
                w_op_next    = OP_ADD;
                w_a1_next    = SUM_ADDR;
                w_a2_next    = w_slot;
            end
            ST_ADD: begin
                w_state_next = ST_READ;
                w_a1_next    = SUM_ADDR;
            end
            default: begin
                w_state_next = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_price      <= '0;
            r_pend_valid <= 1'b0;
            r_pend_price <= '0;
            r_average    <= '0;
            r_avg_valid  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_start) begin
                r_price <= r_pend_valid ? r_pend_price : stock_price;
            end
            if (w_pend_load) begin
                r_pend_valid <= 1'b1;
                r_pend_price <= stock_price;
            end else if (w_start) begin
                r_pend_valid <= 1'b0;
            end
            if (r_state == ST_READ) begin
                r_average <= data_out >> WINDOW_LOG2;
            end
            r_avg_valid <= (r_state == ST_READ);
            r_overrun   <= w_drop;
        end
    end

    assign address_one = r_a1;
    assign address_two = r_a2;
    assign op_code     = r_op;
    assign load_data   = r_load;
    assign average     = r_average;
    assign avg_valid   = r_avg_valid;
    assign busy        = (r_state != ST_IDLE);
    assign window_full = w_window_full;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_avg_sequencer.sv
// tb/tb_avg_sequencer.sv - scoreboard bench for avg_sequencer with a register-file datapath model
module tb_avg_sequencer;

    localparam int WL = 3;
    localparam int N  = 1 << WL;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] stock_price = '0;
    logic        data_ready = 1'b0;
    logic [31:0] data_out;
    logic [4:0]  address_one;
    logic [4:0]  address_two;
    logic [1:0]  op_code;
    logic [31:0] load_data;
    logic [31:0] average;
    logic        avg_valid;
    logic        busy;
    logic        window_full;
    logic        overrun;

    always #5 clk = ~clk;

    avg_sequencer #(.WINDOW_LOG2(WL)) dut (
        .clk         (clk),
        .rst         (rst),
        .stock_price (stock_price),
        .data_ready  (data_ready),
        .data_out    (data_out),
        .address_one (address_one),
        .address_two (address_two),
        .op_code     (op_code),
        .load_data   (load_data),
        .average     (average),
        .avg_valid   (avg_valid),
        .busy        (busy),
        .window_full (window_full),
        .overrun     (overrun)
    );

    // Datapath register file, seeded with junk so INIT clearing is observable.
    logic [31:0] rf [0:31];
    logic        rf_seed = 1'b1;
    assign data_out = rf[address_one];

    always @(posedge clk) begin
        if (rf_seed) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'hA5A5_0000 + 32'(i);
        end else begin
            case (op_code)
                2'b01: rf[address_one] <= load_data;
                2'b10: rf[address_one] <= rf[address_one] + rf[address_two];
                2'b11: rf[address_one] <= rf[address_one] - rf[address_two];
                default: ;
            endcase
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, obs, obs, exp, exp);
        end
    endtask

    logic [31:0] m_win [N];
    int          m_ptr;
    logic [31:0] m_sum;
    logic [31:0] sb [$];

    task automatic model_clear();
        for (int i = 0; i < N; i++) m_win[i] = '0;
        m_ptr = 0;
        m_sum = '0;
        sb.delete();
    endtask

    task automatic model_accept(input logic [31:0] p);
        m_sum = m_sum - m_win[m_ptr] + p;
        m_win[m_ptr] = p;
        m_ptr = (m_ptr + 1) % N;
        sb.push_back(m_sum >> WL);
    endtask

    int cyc = 0;
    int n_valid = 0;
    int n_overrun = 0;
    int last_valid_cyc = 0;
    int prev_valid_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && avg_valid) begin
            n_valid++;
            prev_valid_cyc = last_valid_cyc;
            last_valid_cyc = cyc;
            if (sb.size() == 0) check("avg_unexpected", 32'(avg_valid), 32'd0);
            else                check("avg", average, sb.pop_front());
        end
        if (!rst && overrun) n_overrun++;
    end

    task automatic wait_drain(input string tag);
        int k = 0;
        while ((busy || sb.size() != 0) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_sb"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        data_ready = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wait_drain("init");
    endtask

    task automatic strobe(input logic [31:0] p, input bit accept);
        @(posedge clk);
        #1 stock_price = p;
        data_ready = 1'b1;
        if (accept) model_accept(p);
        @(posedge clk);
        #1 data_ready = 1'b0;
    endtask

    int v0;
    int o0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_average", average, 0);
        check("rst_avg_valid", 32'(avg_valid), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_window_full", 32'(window_full), 0);
        check("rst_busy", 32'(busy), 1);
        check("rst_op", 32'(op_code), 0);
        check("rst_a1", 32'(address_one), 0);
        check("rst_load", load_data, 0);

        @(posedge clk);
        #1 rst = 1'b0;
        rf_seed = 1'b0;
        for (int i = 0; i <= N; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("init_op", 32'(op_code), 1);
            check("init_a1", 32'(address_one), (i == 0) ? 32'd1 : 32'(16 + i - 1));
            check("init_load", load_data, 0);
        end
        @(posedge clk);
        @(negedge clk);
        check("init_busy_fall", 32'(busy), 0);
        check("init_idle_op", 32'(op_code), 0);
        check("init_sum_cleared", rf[1], 0);
        check("init_slot7_cleared", rf[23], 0);

        // single price: full micro-op sequence
        strobe(100, 1);
        @(negedge clk);
        check("seq_sub_op", 32'(op_code), 3);
        check("seq_sub_a1", 32'(address_one), 1);
        check("seq_sub_a2", 32'(address_two), 16);
        @(negedge clk);
        check("seq_load_op", 32'(op_code), 1);
        check("seq_load_a1", 32'(address_one), 16);
        check("seq_load_data", load_data, 100);
        @(negedge clk);
        check("seq_add_op", 32'(op_code), 2);
        check("seq_add_a1", 32'(address_one), 1);
        check("seq_add_a2", 32'(address_two), 16);
        @(negedge clk);
        check("seq_read_op", 32'(op_code), 0);
        check("seq_read_a1", 32'(address_one), 1);
        check("seq_read_busy", 32'(busy), 1);
        check("seq_read_valid", 32'(avg_valid), 0);
        @(negedge clk);
        check("seq_valid", 32'(avg_valid), 1);
        check("seq_avg12", average, 12);
        check("seq_busy_fall", 32'(busy), 0);
        @(negedge clk);
        check("seq_valid_pulse", 32'(avg_valid), 0);

        // fill the window, then wrap
        do_reset();
        for (int k = 1; k <= N; k++) begin
            strobe(32'(100 * k), 1);
            repeat (4) @(posedge clk);
            @(negedge clk);
            if (k == N - 1) check("full_not_yet", 32'(window_full), 0);
        end
        check("full_set", 32'(window_full), 1);
        check("full_avg450", average, 450);
        strobe(900, 1);
        @(negedge clk);
        check("wrap_sub_op", 32'(op_code), 3);
        check("wrap_sub_a2", 32'(address_two), 16);
        wait_drain("wrap");
        check("wrap_avg550", average, 550);

        // back-to-back strobes: second one pending
        do_reset();
        v0 = n_valid;
        @(posedge clk);
        #1 stock_price = 300;
        data_ready = 1'b1;
        model_accept(300);
        @(posedge clk);
        #1 stock_price = 500;
        model_accept(500);
        @(posedge clk);
        #1 data_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pend_sub_op", 32'(op_code), 3);
        check("pend_sub_a2", 32'(address_two), 17);
        wait_drain("pend");
        check("pend_count", 32'(n_valid - v0), 2);
        check("pend_spacing", 32'(last_valid_cyc - prev_valid_cyc), 4);
        check("pend_avg100", average, 100);

        // three strobes: third one overruns
        do_reset();
        v0 = n_valid;
        o0 = n_overrun;
        @(posedge clk);
        #1 stock_price = 100;
        data_ready = 1'b1;
        model_accept(100);
        @(posedge clk);
        #1 stock_price = 200;
        model_accept(200);
        @(posedge clk);
        #1 stock_price = 300;
        @(posedge clk);
        #1 data_ready = 1'b0;
        @(negedge clk);
        check("ovr_pulse", 32'(overrun), 1);
        @(negedge clk);
        check("ovr_pulse_end", 32'(overrun), 0);
        wait_drain("ovr");
        check("ovr_avg_count", 32'(n_valid - v0), 2);
        check("ovr_count", 32'(n_overrun - o0), 1);
        strobe(800, 1);
        wait_drain("ovr_next");
        check("ovr_avg137", average, 137);

        // reset asserted during ADD
        strobe(400, 1);
        @(posedge clk);
        @(posedge clk);
        #1 check("mid_in_add", 32'(op_code), 2);
        rst = 1'b1;
        #1;
        check("mid_op", 32'(op_code), 0);
        check("mid_a1", 32'(address_one), 0);
        check("mid_a2", 32'(address_two), 0);
        check("mid_load", load_data, 0);
        check("mid_average", average, 0);
        check("mid_busy", 32'(busy), 1);
        check("mid_avg_valid", 32'(avg_valid), 0);
        do_reset();
        strobe(800, 1);
        wait_drain("post_rst");
        check("post_rst_avg100", average, 100);
        check("post_rst_full", 32'(window_full), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/avg_sequencer.md
# avg_sequencer

Moving-average sequencer for the stock-price pipeline. It accepts one 32-bit price per `data_ready` strobe and drives the shared register-file datapath through a fixed micro-op sequence. The sequence keeps a running window sum and a circular buffer of the last 2^WINDOW_LOG2 prices, and registers the resulting average. It sits between the price input stage and the datapath block, and is the only master of the datapath's address and op-code ports.

## Interface
- `WINDOW_LOG2`, default 3: window size N = 2^WINDOW_LOG2; legal range 1..4.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `stock_price`  in  32  unsigned price; sampled when `data_ready` is 1.
- `data_ready`  in  1  one-cycle strobe: a new price is valid.
- `data_out`  in  32  datapath read port, combinational: reg[`address_one`].
- `address_one`  out  5  datapath destination / read address.
- `address_two`  out  5  datapath second operand address.
- `op_code`  out  2  datapath op: 00 NOP, 01 LOAD (reg[a1] <= `load_data`), 10 ADD (reg[a1] <= reg[a1] + reg[a2]), 11 SUB (reg[a1] <= reg[a1] - reg[a2]).
- `load_data`  out  32  operand for LOAD.
- `average`  out  32  registered window average.
- `avg_valid`  out  1  one-cycle pulse when `average` updates.
- `busy`  out  1  high while a sequence or init is running.
- `window_full`  out  1  sticky; set once N samples have been accepted.
- `overrun`  out  1  one-cycle pulse when a sample is dropped.

## Operation
- Register map: SUM_ADDR = 1; slots at SLOT_BASE = 16 .. 16+N-1.
- Pointer `ptr` is WINDOW_LOG2 bits wide and addresses the oldest slot.
- States:
  - INIT: runs N+1 cycles of LOAD 0. Order is SUM_ADDR first, then slots ascending. Then go to IDLE.
  - IDLE: NOP. Go to SUB if `data_ready` or pending.
  - SUB: a1 = SUM_ADDR, a2 = SLOT_BASE+ptr. Subtracts the oldest sample.
  - LOAD: a1 = SLOT_BASE+ptr, `load_data` = the latched price.
  - ADD: a1 = SUM_ADDR, a2 = SLOT_BASE+ptr.
  - READ: NOP with a1 = SUM_ADDR.
    - `average` <= `data_out` >> WINDOW_LOG2 (logical shift).
    - `avg_valid` pulses.
    - `ptr` increments, wrapping N-1 -> 0.
    - Sample count saturates at N and sets `window_full`.
    - Next state is SUB if pending is set, else IDLE.
- Before the window fills, empty slots hold 0, so the average is sum/N, not sum/count.
- Arithmetic is modulo 2^32. The upstream stage guarantees the true window sum is < 2^32.
- One-deep pending buffer:
  - A `data_ready` arriving in any state other than IDLE is stored in the buffer.
  - If the buffer is already full, the new sample is dropped and `overrun` pulses. The pending price is kept.
  - `data_ready` in the same cycle as READ while pending is empty is stored and consumed next.
- `data_ready` during INIT goes into pending and is processed after INIT.
- Reset at any time, including mid-sequence:
  - State returns to INIT.
  - `ptr`, count, pending, `window_full` and `average` go to 0.
  - The datapath is re-cleared by INIT.

## Timing
- Reset values:
  - `average` = 0.
  - `avg_valid` = 0, `overrun` = 0, `window_full` = 0.
  - `busy` = 1, because INIT is entered.
  - `op_code` = 00, addresses = 0, `load_data` = 0.
- INIT takes N+1 cycles after `rst` deasserts; `busy` falls on the following edge.
- Sample latency:
  - `data_ready` is sampled in IDLE at edge E0.
  - SUB, LOAD, ADD and READ occupy the cycles E0-E1, E1-E2, E2-E3 and E3-E4.
  - `average` and `avg_valid` are registered at E4; `avg_valid` is high for cycle E4-E5.
- Throughput is one sample per 4 cycles. `busy` is high E0 through E4 and is continuous if pending is set.
- `op_code`, addresses and `load_data` are registered state outputs and are stable for the whole cycle.

## Structure
- Package `avg_pkg`:
  - op-code enum (NOP/LOAD/ADD/SUB);
  - state enum (INIT, IDLE, SUB, LOAD, ADD, READ);
  - SUM_ADDR, SLOT_BASE, ADDR_W = 5, DATA_W = 32.
- Sub-module `avg_window_ptr`: wrap counter for `ptr`, plus the saturating sample count and the `window_full` flag.
- Everything else lives in `avg_sequencer`, including the FSM, pending buffer and output registers.

## Test plan
- Reset release, N=8: 9 cycles of LOAD 0 (addresses 1, 16..23), then `busy` = 0 with `average` = 0.
- Single price 100 -> op sequence SUB(1,16), LOAD(16, 100), ADD(1,16), READ -> `average` = 12, with `avg_valid` one cycle, 4 edges after the strobe.
- Prices 100, 200, ..., 800 spaced 6 cycles -> final `average` = 450 and `window_full` = 1. A ninth price of 900 -> `average` = 550, and SUB uses slot 16 (ptr wrapped).
- Strobes at E0 and E1 (300, then 500, on a cleared window) -> the second is pending and starts SUB at E4. The two `avg_valid` pulses come 4 cycles apart, with averages 37 and 100.
- Strobes at E0, E1 and E2 -> `overrun` pulses at E2, the third price is never loaded, and only two averages are produced.
- `rst` asserted during ADD -> outputs return to reset values at once, INIT re-runs, and the next price 800 -> `average` = 100.
